vcd_window_ctrl: RTL and testbench

Parametrised capture-window controller for simulation waveform dumping and on-chip trace gating. It watches N_TRIG trigger lines, such as GPIOs or core events, and applies a per-channel mask, a pre-trigger delay, a maximum window length and a window budget. From these it produces single-cycle dump-on and dump-off strobes plus a level "dumping" qualifier. It sits beside the testharness on the system clock/reset; the bench turns the strobes into $dumpvars/$dumpoff calls, and trace logic uses the level qualifier.

---
 rtl/vcd_window_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_vcd_window_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/vcd_window_ctrl.sv
// vcd_window_ctrl
// Capture-window controller. It watches masked trigger lines and produces
// one-cycle dump-on/dump-off strobes and a level "dumping" qualifier. The
// pre-trigger delay, maximum window length and window budget shape the window.
//
// State table:
//   S_IDLE     | waiting for a start condition (level: q & armed, toggle: rise)
//   S_DELAY    | pre-trigger delay; level mode aborts to IDLE if q drops
//   S_DUMP_ON  | first dumping cycle, dump_on_o strobe
//   S_ACTIVE   | window open, win_cnt counting
//   S_DUMP_OFF | dump_off_o strobe, window bookkeeping
//   S_DONE     | window budget exhausted, terminal until reset
//
// Ports:
//   vcd_clk, vcd_rst_n - clock, asynchronous active-low reset
//   trig_i             - raw trigger lines, asynchronous to vcd_clk
//   trig_mask_i        - per-channel participation mask (live)
//   mode_i             - 0 level mode, 1 toggle mode (latched at start)
//   pre_delay_i        - cycles from qualification to dump-on (latched)
//   max_len_i          - 0 unlimited, else forced window length (latched)
//   max_windows_i      - 0 unlimited, else window budget (live)
//   dump_on_o          - window-open strobe
//   dump_off_o         - window-close strobe
//   dumping_o          - high while the window is open
//   window_idx_o       - completed window count
//   win_cycles_o       - length of the last completed window
//   trig_src_o         - masked synced triggers captured at qualification
//   done_o             - budget exhausted (sticky)
module vcd_window_ctrl #(
    parameter int N_TRIG      = 4,
    parameter int CNT_W       = 32,
    parameter int WIN_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              vcd_clk,
    input  logic              vcd_rst_n,
    input  logic [N_TRIG-1:0] trig_i,
    input  logic [N_TRIG-1:0] trig_mask_i,
    input  logic              mode_i,
    input  logic [CNT_W-1:0]  pre_delay_i,
    input  logic [CNT_W-1:0]  max_len_i,
    input  logic [WIN_W-1:0]  max_windows_i,
    output logic              dump_on_o,
    output logic              dump_off_o,
    output logic              dumping_o,
    output logic [WIN_W-1:0]  window_idx_o,
    output logic [CNT_W-1:0]  win_cycles_o,
    output logic [N_TRIG-1:0] trig_src_o,
    output logic              done_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_DELAY, S_DUMP_ON, S_ACTIVE, S_DUMP_OFF, S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [N_TRIG-1:0] sync_q [SYNC_STAGES];
    logic [N_TRIG-1:0] trig_s;
    logic              q, q_d_q, rise;

    logic              armed_q, armed_d;
    logic              mode_q, mode_d;
    logic [CNT_W-1:0]  pre_q, pre_d;
    logic [CNT_W-1:0]  max_len_q, max_len_d;
    logic [CNT_W-1:0]  dly_q, dly_d;
    logic [CNT_W-1:0]  win_cnt_q, win_cnt_d;
    logic [CNT_W-1:0]  win_cycles_q, win_cycles_d;
    logic [WIN_W-1:0]  idx_q, idx_d, idx_inc;
    logic [N_TRIG-1:0] src_q, src_d;
    logic              start, close;

    always_ff @(posedge vcd_clk or negedge vcd_rst_n) begin
        if (!vcd_rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= trig_i;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign trig_s  = sync_q[SYNC_STAGES-1];
    assign q       = |(trig_s & trig_mask_i);
    assign rise    = q & ~q_d_q;
    assign idx_inc = idx_q + WIN_W'(1);
    assign start   = mode_i ? rise : (q & armed_q);
    assign close   = (mode_q ? rise : ~q)
                   | ((max_len_q != '0) && (win_cnt_q >= max_len_q));

    always_ff @(posedge vcd_clk or negedge vcd_rst_n) begin
        if (!vcd_rst_n) state_q <= S_IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        pre_d        = pre_q;
        max_len_d    = max_len_q;
        dly_d        = dly_q;
        win_cnt_d    = win_cnt_q;
        win_cycles_d = win_cycles_q;
        idx_d        = idx_q;
        src_d        = src_q;
        // Armed blocks an immediate re-open after a forced close while q stays high.
        if (state_q == S_DUMP_ON) armed_d = 1'b0;
        else if (!q)              armed_d = 1'b1;
        else                      armed_d = armed_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    src_d     = trig_s & trig_mask_i;
                    mode_d    = mode_i;
                    pre_d     = pre_delay_i;
                    max_len_d = max_len_i;
                    dly_d     = '0;
                    win_cnt_d = CNT_W'(1);
                    state_d   = (pre_delay_i != '0) ? S_DELAY : S_DUMP_ON;
                end
            end
            S_DELAY: begin
                if (!mode_q && !q) begin
                    state_d = S_IDLE;
                end else if (dly_q == pre_q - CNT_W'(1)) begin
                    win_cnt_d = CNT_W'(1);
                    state_d   = S_DUMP_ON;
                end else begin
                    dly_d = dly_q + CNT_W'(1);
                end
            end
            S_DUMP_ON: begin
                // win_cnt always equals the 1-based index of the current dumping cycle.
                win_cnt_d = win_cnt_q + CNT_W'(1);
                state_d   = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (close)                 state_d   = S_DUMP_OFF;
                else if (win_cnt_q != '1)  win_cnt_d = win_cnt_q + CNT_W'(1);
            end
            S_DUMP_OFF: begin
                win_cycles_d = win_cnt_q;
                idx_d        = idx_inc;
                if ((max_windows_i != '0) && (idx_inc >= max_windows_i)) state_d = S_DONE;
                else                                                     state_d = S_IDLE;
            end
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge vcd_clk or negedge vcd_rst_n) begin
        if (!vcd_rst_n) begin
            q_d_q        <= 1'b0;
            armed_q      <= 1'b1;
            mode_q       <= 1'b0;
            pre_q        <= '0;
            max_len_q    <= '0;
            dly_q        <= '0;
            win_cnt_q    <= '0;
            win_cycles_q <= '0;
            idx_q        <= '0;
            src_q        <= '0;
        end else begin
            q_d_q        <= q;
            armed_q      <= armed_d;
            mode_q       <= mode_d;
            pre_q        <= pre_d;
            max_len_q    <= max_len_d;
            dly_q        <= dly_d;
            win_cnt_q    <= win_cnt_d;
            win_cycles_q <= win_cycles_d;
            idx_q        <= idx_d;
            src_q        <= src_d;
        end
    end

    assign dump_on_o    = (state_q == S_DUMP_ON);
    assign dump_off_o   = (state_q == S_DUMP_OFF);
    assign dumping_o    = (state_q == S_DUMP_ON) || (state_q == S_ACTIVE);
    assign done_o       = (state_q == S_DONE);
    assign window_idx_o = idx_q;
    assign win_cycles_o = win_cycles_q;
    assign trig_src_o   = src_q;

endmodule

// File: tb/tb_vcd_window_ctrl.sv
// Directed bench for vcd_window_ctrl with SYNC_STAGES = 2 and N_TRIG = 4.
module tb_vcd_window_ctrl;

    logic        vcd_clk = 1'b0;
    logic        vcd_rst_n = 1'b0;
    logic [3:0]  trig_i = '0;
    logic [3:0]  trig_mask_i = '0;
    logic        mode_i = 1'b0;
    logic [31:0] pre_delay_i = '0;
    logic [31:0] max_len_i = '0;
    logic [7:0]  max_windows_i = '0;
    logic        dump_on_o, dump_off_o, dumping_o, done_o;
    logic [7:0]  window_idx_o;
    logic [31:0] win_cycles_o;
    logic [3:0]  trig_src_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Observation results of the last run_pulses call.
    int n_on, n_off, n_dump, on_edge, overlap;

    vcd_window_ctrl #(.N_TRIG(4), .CNT_W(32), .WIN_W(8), .SYNC_STAGES(2)) dut (
        .vcd_clk      (vcd_clk),
        .vcd_rst_n    (vcd_rst_n),
        .trig_i       (trig_i),
        .trig_mask_i  (trig_mask_i),
        .mode_i       (mode_i),
        .pre_delay_i  (pre_delay_i),
        .max_len_i    (max_len_i),
        .max_windows_i(max_windows_i),
        .dump_on_o    (dump_on_o),
        .dump_off_o   (dump_off_o),
        .dumping_o    (dumping_o),
        .window_idx_o (window_idx_o),
        .win_cycles_o (win_cycles_o),
        .trig_src_o   (trig_src_o),
        .done_o       (done_o)
    );

    always #5 vcd_clk = ~vcd_clk;

    task automatic do_reset();
        trig_i    = '0;
        vcd_rst_n = 1'b0;
        repeat (3) @(posedge vcd_clk);
        #1 vcd_rst_n = 1'b1;
    endtask

    // Drives ch during up to three pulses (start cycle, length) over n cycles.
    // Iteration c drives before edge c+1 and samples 1 unit after it.
    task automatic run_pulses(input int n, input logic [3:0] ch,
                              input int s1, input int l1, input int s2, input int l2,
                              input int s3, input int l3);
        n_on = 0; n_off = 0; n_dump = 0; on_edge = -1; overlap = 0;
        for (int c = 0; c < n; c++) begin
            if ((c >= s1 && c < s1 + l1) || (c >= s2 && c < s2 + l2) || (c >= s3 && c < s3 + l3))
                trig_i = ch;
            else
                trig_i = '0;
            @(posedge vcd_clk);
            #1;
            if (dump_on_o) begin
                n_on++;
                if (on_edge < 0) on_edge = c + 1;
            end
            if (dump_off_o) n_off++;
            if (dumping_o) n_dump++;
            if (dump_on_o && dump_off_o) overlap++;
        end
        trig_i = '0;
    endtask

    task automatic test_reset();
        mode_i = 0; pre_delay_i = 0; max_len_i = 0; max_windows_i = 0; trig_mask_i = 4'b0001;
        do_reset();
        n_checks++; if ({dump_on_o, dump_off_o, dumping_o, done_o} !== 4'b0000) begin n_fail++; $display("FAIL reset_strobes got %b want 0000", {dump_on_o, dump_off_o, dumping_o, done_o}); end
        n_checks++; if (window_idx_o !== 8'd0) begin n_fail++; $display("FAIL reset_idx got %0d want 0", window_idx_o); end
        n_checks++; if (win_cycles_o !== 32'd0 || trig_src_o !== 4'd0) begin n_fail++; $display("FAIL reset_regs got %0d/%b want 0/0000", win_cycles_o, trig_src_o); end
    endtask

    task automatic test_level_basic();
        mode_i = 0; pre_delay_i = 0; max_len_i = 0; max_windows_i = 0; trig_mask_i = 4'b0001;
        do_reset();
        run_pulses(20, 4'b0001, 0, 10, 0, 0, 0, 0);
        n_checks++; if (n_on !== 1 || n_off !== 1) begin n_fail++; $display("FAIL level_strobes got on=%0d off=%0d want 1/1", n_on, n_off); end
        n_checks++; if (on_edge !== 3) begin n_fail++; $display("FAIL level_latency got %0d want 3", on_edge); end
        n_checks++; if (n_dump !== 10) begin n_fail++; $display("FAIL level_dumping got %0d want 10", n_dump); end
        n_checks++; if (win_cycles_o !== 32'd10) begin n_fail++; $display("FAIL level_win_cycles got %0d want 10", win_cycles_o); end
        n_checks++; if (window_idx_o !== 8'd1) begin n_fail++; $display("FAIL level_idx got %0d want 1", window_idx_o); end
        n_checks++; if (trig_src_o !== 4'b0001) begin n_fail++; $display("FAIL level_src got %b want 0001", trig_src_o); end
        n_checks++; if (overlap !== 0) begin n_fail++; $display("FAIL level_overlap got %0d want 0", overlap); end
    endtask

    task automatic test_mask();
        mode_i = 0; pre_delay_i = 0; max_len_i = 0; max_windows_i = 0; trig_mask_i = 4'b0001;
        do_reset();
        run_pulses(15, 4'b1000, 0, 8, 0, 0, 0, 0);
        n_checks++; if (n_on !== 0 || window_idx_o !== 8'd0) begin n_fail++; $display("FAIL mask_ignored got on=%0d idx=%0d want 0/0", n_on, window_idx_o); end
    endtask

    task automatic test_delay();
        mode_i = 0; pre_delay_i = 5; max_len_i = 0; max_windows_i = 0; trig_mask_i = 4'b0010;
        do_reset();
        run_pulses(20, 4'b0010, 0, 3, 0, 0, 0, 0);
        n_checks++; if (n_on !== 0 || n_off !== 0 || n_dump !== 0) begin n_fail++; $display("FAIL delay_abort got on=%0d off=%0d dump=%0d want 0/0/0", n_on, n_off, n_dump); end
        n_checks++; if (window_idx_o !== 8'd0) begin n_fail++; $display("FAIL delay_abort_idx got %0d want 0", window_idx_o); end
        do_reset();
        run_pulses(35, 4'b0010, 0, 20, 0, 0, 0, 0);
        n_checks++; if (on_edge !== 8) begin n_fail++; $display("FAIL delay_latency got %0d want 8", on_edge); end
        n_checks++; if (win_cycles_o !== 32'd15 || n_dump !== 15) begin n_fail++; $display("FAIL delay_len got %0d/%0d want 15/15", win_cycles_o, n_dump); end
        n_checks++; if (window_idx_o !== 8'd1) begin n_fail++; $display("FAIL delay_idx got %0d want 1", window_idx_o); end
    endtask

    task automatic test_max_len();
        mode_i = 0; pre_delay_i = 0; max_len_i = 4; max_windows_i = 0; trig_mask_i = 4'b0001;
        do_reset();
        run_pulses(40, 4'b0001, 0, 30, 0, 0, 0, 0);
        n_checks++; if (n_on !== 1 || n_dump !== 4) begin n_fail++; $display("FAIL maxlen_single got on=%0d dump=%0d want 1/4", n_on, n_dump); end
        n_checks++; if (win_cycles_o !== 32'd4 || window_idx_o !== 8'd1) begin n_fail++; $display("FAIL maxlen_regs got %0d/%0d want 4/1", win_cycles_o, window_idx_o); end
        run_pulses(20, 4'b0001, 0, 10, 0, 0, 0, 0);
        n_checks++; if (n_on !== 1 || window_idx_o !== 8'd2) begin n_fail++; $display("FAIL maxlen_rearm got on=%0d idx=%0d want 1/2", n_on, window_idx_o); end
        max_len_i = 1;
        run_pulses(20, 4'b0001, 0, 10, 0, 0, 0, 0);
        n_checks++; if (n_dump !== 2 || win_cycles_o !== 32'd2) begin n_fail++; $display("FAIL maxlen_one got %0d/%0d want 2/2", n_dump, win_cycles_o); end
    endtask

    task automatic test_toggle();
        mode_i = 1; pre_delay_i = 0; max_len_i = 0; max_windows_i = 0; trig_mask_i = 4'b0100;
        do_reset();
        run_pulses(25, 4'b0100, 0, 2, 12, 2, 0, 0);
        n_checks++; if (n_on !== 1 || n_off !== 1) begin n_fail++; $display("FAIL toggle_strobes got on=%0d off=%0d want 1/1", n_on, n_off); end
        n_checks++; if (win_cycles_o !== 32'd12 || n_dump !== 12) begin n_fail++; $display("FAIL toggle_len got %0d/%0d want 12/12", win_cycles_o, n_dump); end
        n_checks++; if (trig_src_o !== 4'b0100) begin n_fail++; $display("FAIL toggle_src got %b want 0100", trig_src_o); end
        mode_i = 0;
    endtask

    task automatic test_budget();
        mode_i = 0; pre_delay_i = 0; max_len_i = 0; max_windows_i = 2; trig_mask_i = 4'b0001;
        do_reset();
        run_pulses(35, 4'b0001, 0, 4, 10, 4, 20, 4);
        n_checks++; if (n_on !== 2 || n_off !== 2) begin n_fail++; $display("FAIL budget_windows got on=%0d off=%0d want 2/2", n_on, n_off); end
        n_checks++; if (window_idx_o !== 8'd2 || done_o !== 1'b1) begin n_fail++; $display("FAIL budget_done got idx=%0d done=%b want 2/1", window_idx_o, done_o); end
        n_checks++; if (win_cycles_o !== 32'd4) begin n_fail++; $display("FAIL budget_len got %0d want 4", win_cycles_o); end
        max_windows_i = 0;
    endtask

    task automatic test_reset_mid();
        mode_i = 0; pre_delay_i = 0; max_len_i = 0; max_windows_i = 0; trig_mask_i = 4'b0001;
        do_reset();
        run_pulses(12, 4'b0001, 0, 4, 0, 0, 0, 0);
        run_pulses(6, 4'b0001, 0, 20, 0, 0, 0, 0);
        n_checks++; if (dumping_o !== 1'b1 || window_idx_o !== 8'd1) begin n_fail++; $display("FAIL midreset_pre got dump=%b idx=%0d want 1/1", dumping_o, window_idx_o); end
        #2 vcd_rst_n = 1'b0;
        #1;
        n_checks++; if ({dump_on_o, dump_off_o, dumping_o, done_o} !== 4'b0000 || window_idx_o !== 8'd0) begin n_fail++; $display("FAIL midreset_clear got %b idx=%0d want 0000/0", {dump_on_o, dump_off_o, dumping_o, done_o}, window_idx_o); end
        n_checks++; if (win_cycles_o !== 32'd0 || trig_src_o !== 4'd0) begin n_fail++; $display("FAIL midreset_regs got %0d/%b want 0/0000", win_cycles_o, trig_src_o); end
        do_reset();
        run_pulses(20, 4'b0001, 0, 10, 0, 0, 0, 0);
        n_checks++; if (win_cycles_o !== 32'd10 || window_idx_o !== 8'd1 || on_edge !== 3) begin n_fail++; $display("FAIL midreset_after got %0d/%0d/%0d want 10/1/3", win_cycles_o, window_idx_o, on_edge); end
    endtask

    initial begin
        test_reset();
        test_level_basic();
        test_mask();
        test_delay();
        test_max_len();
        test_toggle();
        test_budget();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
